// File: rtl/core_bram_stream_reader.sv
// Sequential BRAM read engine: issues consecutive addresses (modulo Depth), absorbs
// the 1-cycle read latency and presents the words as a valid/ready stream.
module core_bram_stream_reader #(
  parameter int DataWidth = 8,
  parameter int Depth     = 784,
  parameter int AddrW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrW-1:0]     base_addr_i,
  input  logic [AddrW-1:0]     length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrW-1:0]     bram_addr_o,
  output logic                 bram_write_en_o,
  input  logic [DataWidth-1:0] bram_data_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);
  localparam logic [AddrW-1:0] OneWord  = AddrW'(1);

  state_t               state_reg, state_next;
  logic [AddrW-1:0]     addr_cnt_reg, addr_cnt_next;
  logic [AddrW-1:0]     issue_left_reg, issue_left_next;
  logic [AddrW-1:0]     addr_hold_reg;
  logic                 inflight_reg;
  logic [1:0]           fifo_count_reg;
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [DataWidth-1:0] fifo_mem_reg [2];

  logic       issue;
  logic       push;
  logic       pop;
  logic [2:0] credit;

  assign push      = inflight_reg;
  assign m_valid_o = (fifo_count_reg != 2'd0);
  assign pop       = m_valid_o & m_ready_i;
  assign m_data_o  = fifo_mem_reg[rd_ptr_reg];

  // Occupancy the FIFO will have after this cycle's pop plus the word already
  // in flight; one more read fits only while this stays at 1 or below.
  assign credit = {1'b0, fifo_count_reg} - {2'b00, pop} + {2'b00, inflight_reg};

  assign busy_o          = (state_reg != ST_IDLE);
  assign done_o          = (state_reg == ST_DONE);
  assign bram_write_en_o = 1'b0;
  assign bram_addr_o     = issue ? addr_cnt_reg : addr_hold_reg;

  always_comb begin
    state_next      = state_reg;
    addr_cnt_next   = addr_cnt_reg;
    issue_left_next = issue_left_reg;
    issue           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          addr_cnt_next   = base_addr_i;
          issue_left_next = length_i;
          state_next      = (length_i == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        issue = (credit <= 3'd1);
        if (issue) begin
          addr_cnt_next   = (addr_cnt_reg == LastAddr) ? '0 : addr_cnt_reg + OneWord;
          issue_left_next = issue_left_reg - OneWord;
          if (issue_left_reg == OneWord) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Finish once the buffer empties on this cycle's handshake and nothing is in flight.
        if (!inflight_reg &&
            ((fifo_count_reg == 2'd0) || ((fifo_count_reg == 2'd1) && pop))) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      addr_cnt_reg   <= '0;
      issue_left_reg <= '0;
      addr_hold_reg  <= '0;
      inflight_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_cnt_reg   <= addr_cnt_next;
      issue_left_reg <= issue_left_next;
      inflight_reg   <= issue;
      if (issue) begin
        addr_hold_reg <= addr_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_count_reg <= 2'd0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
    end else begin
      fifo_count_reg <= fifo_count_reg + {1'b0, push} - {1'b0, pop};
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          fifo_mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_mem_reg[gi] <= bram_data_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_core_bram_stream_reader.sv
// Directed bench for core_bram_stream_reader with a behavioural 1-cycle-latency BRAM
// preloaded with mem[i] = i (low 8 bits).
module tb_core_bram_stream_reader;
  localparam int DW    = 8;
  localparam int DEPTH = 784;
  localparam int AW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  logic [DW-1:0] mem [DEPTH];

  int nvec = 0;
  int nerr = 0;

  int got_data [64];
  int got_addr [64];
  int got_n, got_nissue, got_done_cyc, got_ahead, got_unstable, got_oob;

  always #5 clk = ~clk;

  core_bram_stream_reader #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .base_addr_i    (base_addr),
    .length_i       (length),
    .busy_o         (busy),
    .done_o         (done),
    .bram_addr_o    (bram_addr),
    .bram_write_en_o(bram_we),
    .bram_data_i    (bram_data),
    .m_data_o       (m_data),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready)
  );

  always @(posedge clk) begin
    if (int'(bram_addr) < DEPTH) bram_data <= mem[bram_addr];
    else bram_data <= 'x;
  end

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
    return 1'b0;
  endfunction

  // Runs one job and records beats, issued addresses and stream properties.
  task automatic run_job(input int base, input int len, input int mode, input int restart_cyc);
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic          prev_stall;
    logic          done_seen;
    got_n = 0; got_nissue = 0; got_done_cyc = -1; got_ahead = 0; got_unstable = 0; got_oob = 0;
    start = 1'b1; base_addr = AW'(base); length = AW'(len); m_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    prev_addr = '0; prev_data = '0; prev_stall = 1'b0; done_seen = 1'b0;
    for (int c = 1; c < 200; c++) begin
      m_ready = ready_for(mode, c);
      if (c == restart_cyc) begin
        start = 1'b1; base_addr = AW'(100); length = AW'(6);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 1 || bram_addr != prev_addr) begin
        if (got_nissue < 64) got_addr[got_nissue] = int'(bram_addr);
        got_nissue++;
      end
      if (int'(bram_addr) >= DEPTH) got_oob++;
      if (prev_stall && m_valid && m_data !== prev_data) got_unstable++;
      if (m_valid && m_ready) begin
        if (got_n < 64) got_data[got_n] = int'(m_data);
        got_n++;
      end
      if (got_nissue - got_n > got_ahead) got_ahead = got_nissue - got_n;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_addr  = bram_addr;
      if (done && !done_seen) begin
        done_seen = 1'b1;
        got_done_cyc = c;
      end
      if (done_seen && !busy) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    $display("job base=%0d len=%0d beats=%0d issues=%0d done_cycle=%0d", base, len, got_n, got_nissue, got_done_cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%0b exp=0", done); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%0b exp=0", m_valid); end
    nvec++; if (m_data !== '0) begin nerr++; $display("FAIL reset_data got=%0d exp=0", m_data); end
    nvec++; if (bram_addr !== '0) begin nerr++; $display("FAIL reset_addr got=%0d exp=0", bram_addr); end
    nvec++; if (bram_we !== 1'b0) begin nerr++; $display("FAIL reset_we got=%0b exp=0", bram_we); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_basic();
    logic exp_busy, exp_done, exp_valid;
    start = 1'b1; base_addr = AW'(10); length = AW'(5); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_busy  = (c <= 8);
      exp_done  = (c == 8);
      exp_valid = (c >= 3) && (c <= 7);
      nvec++; if (busy !== exp_busy) begin nerr++; $display("FAIL basic_busy c=%0d got=%0b exp=%0b", c, busy, exp_busy); end
      nvec++; if (done !== exp_done) begin nerr++; $display("FAIL basic_done c=%0d got=%0b exp=%0b", c, done, exp_done); end
      nvec++; if (m_valid !== exp_valid) begin nerr++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, m_valid, exp_valid); end
      if (exp_valid) begin
        nvec++; if (m_data !== DW'(10 + c - 3)) begin nerr++; $display("FAIL basic_data c=%0d got=%0d exp=%0d", c, m_data, 10 + c - 3); end
      end
      if (c == 1) begin
        nvec++; if (bram_addr !== AW'(10)) begin nerr++; $display("FAIL basic_addr c=1 got=%0d exp=10", bram_addr); end
      end
      @(posedge clk); #1;
    end
    $display("basic job base=10 len=5 checked");
  endtask

  task automatic test_len0();
    start = 1'b1; base_addr = AW'(5); length = AW'(0); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL len0_done c=1 got=%0b exp=1", done); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL len0_busy c=1 got=%0b exp=1", busy); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL len0_valid c=1 got=%0b exp=0", m_valid); end
    nvec++; if (bram_addr !== AW'(14)) begin nerr++; $display("FAIL len0_addr got=%0d exp=14", bram_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL len0_done c=2 got=%0b exp=0", done); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL len0_busy c=2 got=%0b exp=0", busy); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL len0_valid c=2 got=%0b exp=0", m_valid); end
    @(posedge clk); #1;
    $display("len0 job checked");
  endtask

  task automatic test_wrap();
    int exp_addr [4];
    exp_addr[0] = 782; exp_addr[1] = 783; exp_addr[2] = 0; exp_addr[3] = 1;
    run_job(782, 4, 0, -1);
    nvec++; if (got_nissue !== 4) begin nerr++; $display("FAIL wrap_issues got=%0d exp=4", got_nissue); end
    nvec++; if (got_n !== 4) begin nerr++; $display("FAIL wrap_beats got=%0d exp=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      nvec++; if (got_addr[i] !== exp_addr[i]) begin nerr++; $display("FAIL wrap_addr i=%0d got=%0d exp=%0d", i, got_addr[i], exp_addr[i]); end
      nvec++; if (got_data[i] !== (exp_addr[i] % 256)) begin nerr++; $display("FAIL wrap_data i=%0d got=%0d exp=%0d", i, got_data[i], exp_addr[i] % 256); end
    end
    nvec++; if (got_oob !== 0) begin nerr++; $display("FAIL wrap_oob got=%0d exp=0", got_oob); end
    nvec++; if (got_done_cyc !== 7) begin nerr++; $display("FAIL wrap_done_cycle got=%0d exp=7", got_done_cyc); end
  endtask

  task automatic test_backpressure();
    run_job(0, 8, 1, -1);
    nvec++; if (got_n !== 8) begin nerr++; $display("FAIL bp_beats got=%0d exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      nvec++; if (got_data[i] !== i) begin nerr++; $display("FAIL bp_data i=%0d got=%0d exp=%0d", i, got_data[i], i); end
    end
    nvec++; if (got_unstable !== 0) begin nerr++; $display("FAIL bp_stall_stable got=%0d exp=0", got_unstable); end
    nvec++; if (got_ahead > 2) begin nerr++; $display("FAIL bp_ahead got=%0d exp<=2", got_ahead); end
    nvec++; if (got_done_cyc < 0) begin nerr++; $display("FAIL bp_done got=%0d exp=seen", got_done_cyc); end
  endtask

  task automatic test_back_to_back();
    run_job(20, 3, 0, 2);
    nvec++; if (got_n !== 3) begin nerr++; $display("FAIL restart_beats got=%0d exp=3", got_n); end
    for (int i = 0; i < 3; i++) begin
      nvec++; if (got_data[i] !== 20 + i) begin nerr++; $display("FAIL restart_data i=%0d got=%0d exp=%0d", i, got_data[i], 20 + i); end
    end
    nvec++; if (got_done_cyc !== 6) begin nerr++; $display("FAIL restart_done_cycle got=%0d exp=6", got_done_cyc); end
    run_job(30, 2, 0, -1);
    nvec++; if (got_n !== 2) begin nerr++; $display("FAIL second_beats got=%0d exp=2", got_n); end
    for (int i = 0; i < 2; i++) begin
      nvec++; if (got_data[i] !== 30 + i) begin nerr++; $display("FAIL second_data i=%0d got=%0d exp=%0d", i, got_data[i], 30 + i); end
    end
    nvec++; if (got_done_cyc !== 5) begin nerr++; $display("FAIL second_done_cycle got=%0d exp=5", got_done_cyc); end
  endtask

  task automatic test_reset_midjob();
    start = 1'b1; base_addr = AW'(40); length = AW'(6); m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL midrst_pre_valid got=%0b exp=1", m_valid); end
    nvec++; if (m_data !== DW'(40)) begin nerr++; $display("FAIL midrst_pre_data got=%0d exp=40", m_data); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid got=%0b exp=0", m_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    nvec++; if (bram_addr !== '0) begin nerr++; $display("FAIL midrst_addr got=%0d exp=0", bram_addr); end
    nvec++; if (m_data !== '0) begin nerr++; $display("FAIL midrst_data got=%0d exp=0", m_data); end
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    run_job(50, 3, 0, -1);
    nvec++; if (got_n !== 3) begin nerr++; $display("FAIL postrst_beats got=%0d exp=3", got_n); end
    for (int i = 0; i < 3; i++) begin
      nvec++; if (got_data[i] !== 50 + i) begin nerr++; $display("FAIL postrst_data i=%0d got=%0d exp=%0d", i, got_data[i], 50 + i); end
    end
    nvec++; if (got_done_cyc !== 6) begin nerr++; $display("FAIL postrst_done_cycle got=%0d exp=6", got_done_cyc); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
